// File: rtl/dsi_pkg.sv
// Shared D-PHY lane definitions: state encoding, LP line levels and per-state
// output decode used by the clock lane and the data-lane controllers.
package dsi_pkg;

  typedef logic [3:0] dsi_state_t;
  typedef logic [1:0] lp_lvl_t;  // {p, n}

  localparam dsi_state_t ST_LP11      = 4'd0;
  localparam dsi_state_t ST_LP01      = 4'd1;
  localparam dsi_state_t ST_LP00      = 4'd2;
  localparam dsi_state_t ST_HS_ZERO   = 4'd3;
  localparam dsi_state_t ST_HS_PRE    = 4'd4;
  localparam dsi_state_t ST_HS_CLK    = 4'd5;
  localparam dsi_state_t ST_HS_POST   = 4'd6;
  localparam dsi_state_t ST_HS_TRAIL  = 4'd7;
  localparam dsi_state_t ST_ULPS_ENT  = 4'd8;
  localparam dsi_state_t ST_ULPS      = 4'd9;
  localparam dsi_state_t ST_ULPS_EXIT = 4'd10;

  localparam lp_lvl_t LP_11 = 2'b11;
  localparam lp_lvl_t LP_01 = 2'b01;
  localparam lp_lvl_t LP_10 = 2'b10;
  localparam lp_lvl_t LP_00 = 2'b00;

  function automatic lp_lvl_t lp_level(dsi_state_t st);
    lp_lvl_t lvl;
    case (st)
      ST_LP11:                   lvl = LP_11;
      ST_LP01:                   lvl = LP_01;
      ST_ULPS_ENT, ST_ULPS_EXIT: lvl = LP_10;
      default:                   lvl = LP_00;
    endcase
    return lvl;
  endfunction

  function automatic logic hs_oe_state(dsi_state_t st);
    return st inside {ST_HS_ZERO, ST_HS_PRE, ST_HS_CLK, ST_HS_POST, ST_HS_TRAIL};
  endfunction

  // Only these states carry clock edges; HS_ZERO and HS_TRAIL hold the line at 0.
  function automatic logic hs_bit_state(dsi_state_t st);
    return st inside {ST_HS_PRE, ST_HS_CLK, ST_HS_POST};
  endfunction

endpackage

// File: rtl/dsi_lane_timer.sv
// Phase down-counter: loads a duration, then decrements; trig is the MSB, so a
// zero-extended load of N raises trig after N+1 decrements.
module dsi_lane_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         trig_o
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = load_i ? value_i : count_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '1;
    end else begin
      count_q <= count_d;
    end
  end

  assign trig_o = count_q[W-1];

endmodule

// File: rtl/dsi_clk_lane.sv
// MIPI D-PHY clock-lane controller: LP request/HS entry/exit sequencing, ULPS
// entry/exit and optional continuous clock, with registered lane IO controls.
module dsi_clk_lane
  import dsi_pkg::*;
#(
  parameter int unsigned TIMER_W  = 8,
  parameter int unsigned WAKE_W   = 16,
  parameter bit          CONT_CLK = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hs_req,
  output logic               hs_rdy,
  input  logic               ulps_req,
  output logic               ulps_active,
  output logic               clk_sync,
  input  logic [TIMER_W-1:0] cfg_lpx,
  input  logic [TIMER_W-1:0] cfg_hs_prep,
  input  logic [TIMER_W-1:0] cfg_hs_zero,
  input  logic [TIMER_W-1:0] cfg_hs_pre,
  input  logic [TIMER_W-1:0] cfg_hs_post,
  input  logic [TIMER_W-1:0] cfg_hs_trail,
  input  logic [WAKE_W-1:0]  cfg_wakeup,
  output logic               io_lp_p,
  output logic               io_lp_n,
  output logic               io_hs_oe,
  output logic               io_hs_bit
);

  // One spare bit so an all-ones cfg still counts down before the MSB sets.
  localparam int unsigned TW = ((TIMER_W > WAKE_W) ? TIMER_W : WAKE_W) + 1;

  dsi_state_t    state_d, state_q;
  logic          clk_sync_d, clk_sync_q;
  lp_lvl_t       lp_d, lp_q;
  logic          hs_oe_d, hs_oe_q;
  logic          hs_bit_d, hs_bit_q;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          trig;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LP11: begin
        if (ulps_req) begin
          state_d = ST_ULPS_ENT;
        end else if (hs_req || CONT_CLK) begin
          state_d = ST_LP01;
        end
      end
      ST_LP01:     if (trig) state_d = ST_LP00;
      ST_LP00:     if (trig) state_d = ST_HS_ZERO;
      ST_HS_ZERO:  if (trig) state_d = ST_HS_PRE;
      ST_HS_PRE:   if (trig) state_d = ST_HS_CLK;
      ST_HS_CLK: begin
        if (ulps_req || (!CONT_CLK && !hs_req)) state_d = ST_HS_POST;
      end
      ST_HS_POST:   if (trig) state_d = ST_HS_TRAIL;
      ST_HS_TRAIL:  if (trig) state_d = ST_LP11;
      ST_ULPS_ENT:  if (trig) state_d = ST_ULPS;
      ST_ULPS:      if (!ulps_req) state_d = ST_ULPS_EXIT;
      ST_ULPS_EXIT: if (trig) state_d = ST_LP11;
      default:      state_d = ST_LP11;
    endcase
  end

  // Duration of the state being entered; cfg is captured only here.
  always_comb begin
    timer_val = '1;
    case (state_d)
      ST_LP01, ST_ULPS_ENT: timer_val = TW'(cfg_lpx);
      ST_LP00:              timer_val = TW'(cfg_hs_prep);
      ST_HS_ZERO:           timer_val = TW'(cfg_hs_zero);
      ST_HS_PRE:            timer_val = TW'(cfg_hs_pre);
      ST_HS_POST:           timer_val = TW'(cfg_hs_post);
      ST_HS_TRAIL:          timer_val = TW'(cfg_hs_trail);
      ST_ULPS_EXIT:         timer_val = TW'(cfg_wakeup);
      default:              ;
    endcase
  end

  assign timer_load = (state_d != state_q);

  dsi_lane_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .value_i(timer_val),
    .trig_o (trig)
  );

  always_comb begin
    clk_sync_d = ~clk_sync_q;
    lp_d       = lp_level(state_q);
    hs_oe_d    = hs_oe_state(state_q);
    hs_bit_d   = clk_sync_q & hs_bit_state(state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LP11;
      clk_sync_q <= 1'b0;
      lp_q       <= LP_11;
      hs_oe_q    <= 1'b0;
      hs_bit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      lp_q       <= lp_d;
      hs_oe_q    <= hs_oe_d;
      hs_bit_q   <= hs_bit_d;
    end
  end

  assign hs_rdy      = (state_q == ST_HS_CLK);
  assign ulps_active = (state_q == ST_ULPS);
  assign clk_sync    = clk_sync_q;
  assign io_lp_p     = lp_q[1];
  assign io_lp_n     = lp_q[0];
  assign io_hs_oe    = hs_oe_q;
  assign io_hs_bit   = hs_bit_q;

endmodule

// File: tb/tb_dsi_clk_lane.sv
// Scoreboard bench: transactions are expanded into phase timelines by arithmetic
// on the cfg durations; a monitor compares every sampled cycle of the lane.
module tb_dsi_clk_lane;

  localparam int unsigned TW = 8;
  localparam int unsigned WW = 16;

  localparam int PH_RST = -1;
  localparam int PH_LP11 = 0, PH_LP01 = 1, PH_LP00 = 2, PH_ZERO = 3, PH_PRE = 4, PH_CLK = 5;
  localparam int PH_POST = 6, PH_TRAIL = 7, PH_UENT = 8, PH_ULPS = 9, PH_UEXIT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_c_n;
  logic          hs_req, ulps_req;
  logic [TW-1:0] cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_pre, cfg_hs_post, cfg_hs_trail;
  logic [WW-1:0] cfg_wakeup;
  logic hs_rdy, ulps_active, clk_sync, io_lp_p, io_lp_n, io_hs_oe, io_hs_bit;
  logic hs_rdy_c, ulps_active_c, clk_sync_c, io_lp_p_c, io_lp_n_c, io_hs_oe_c, io_hs_bit_c;

  dsi_clk_lane #(.TIMER_W(TW), .WAKE_W(WW), .CONT_CLK(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .hs_req(hs_req), .hs_rdy(hs_rdy), .ulps_req(ulps_req),
    .ulps_active(ulps_active), .clk_sync(clk_sync), .cfg_lpx(cfg_lpx),
    .cfg_hs_prep(cfg_hs_prep), .cfg_hs_zero(cfg_hs_zero), .cfg_hs_pre(cfg_hs_pre),
    .cfg_hs_post(cfg_hs_post), .cfg_hs_trail(cfg_hs_trail), .cfg_wakeup(cfg_wakeup),
    .io_lp_p(io_lp_p), .io_lp_n(io_lp_n), .io_hs_oe(io_hs_oe), .io_hs_bit(io_hs_bit)
  );

  dsi_clk_lane #(.TIMER_W(TW), .WAKE_W(WW), .CONT_CLK(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_c_n), .hs_req(hs_req), .hs_rdy(hs_rdy_c), .ulps_req(ulps_req),
    .ulps_active(ulps_active_c), .clk_sync(clk_sync_c), .cfg_lpx(cfg_lpx),
    .cfg_hs_prep(cfg_hs_prep), .cfg_hs_zero(cfg_hs_zero), .cfg_hs_pre(cfg_hs_pre),
    .cfg_hs_post(cfg_hs_post), .cfg_hs_trail(cfg_hs_trail), .cfg_wakeup(cfg_wakeup),
    .io_lp_p(io_lp_p_c), .io_lp_n(io_lp_n_c), .io_hs_oe(io_hs_oe_c), .io_hs_bit(io_hs_bit_c)
  );

  // Input codes: 0, 1, or 2 = random (the lane must ignore it there).
  typedef struct {
    int ph; int len; int hs_b; int ul_b; int hs_l; int ul_l; int cfg;
  } seg_t;
  typedef struct {
    logic hs; logic ul;
    logic [TW-1:0] lpx, prep, zero, pre, post, trail;
    logic [WW-1:0] wake;
  } stim_t;
  typedef struct { int ph; bit first; bit sel; } exp_t;

  seg_t  seg_q[$];
  stim_t in_q[$];
  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic int rr(int lo, int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic logic pick(int code);
    return (code == 2) ? 1'($urandom_range(1, 0)) : (code != 0);
  endfunction

  function automatic stim_t set_cfg(stim_t st, int ph, int v);
    stim_t s = st;
    case (ph)
      PH_LP01, PH_UENT: s.lpx = TW'(v);
      PH_LP00:          s.prep = TW'(v);
      PH_ZERO:          s.zero = TW'(v);
      PH_PRE:           s.pre = TW'(v);
      PH_POST:          s.post = TW'(v);
      PH_TRAIL:         s.trail = TW'(v);
      PH_UEXIT:         s.wake = WW'(v);
      default:          ;
    endcase
    return s;
  endfunction

  task automatic add(int ph, int len, int hs_b, int ul_b, int hs_l, int ul_l, int cfg);
    seg_t s;
    s.ph = ph; s.len = len; s.hs_b = hs_b; s.ul_b = ul_b; s.hs_l = hs_l; s.ul_l = ul_l;
    s.cfg = cfg;
    seg_q.push_back(s);
  endtask

  task automatic add_idle(int len, int hs_l, int ul_l);
    add(PH_LP11, len, 0, 0, hs_l, ul_l, 0);
  endtask

  // Timed phases last cfg + 2 cycles; requests are don't-care throughout entry.
  task automatic add_entry(int lpx, int prep, int zero, int pre);
    add(PH_LP01, lpx + 2, 2, 2, 2, 2, lpx);
    add(PH_LP00, prep + 2, 2, 2, 2, 2, prep);
    add(PH_ZERO, zero + 2, 2, 2, 2, 2, zero);
    add(PH_PRE, pre + 2, 2, 2, 2, 2, pre);
  endtask

  task automatic add_tail(int h, bit via_ulps, bit cont, int post, int trail);
    add(PH_CLK, h, cont ? 2 : 1, 0, via_ulps ? 2 : 0, via_ulps ? 1 : 2, 0);
    add(PH_POST, post + 2, 2, 2, 2, 2, post);
    add(PH_TRAIL, trail + 2, 2, 2, 2, 2, trail);
  endtask

  task automatic add_ulps(int lpx, int u, int wake);
    add(PH_UENT, lpx + 2, 2, 2, 2, 2, lpx);
    add(PH_ULPS, u, 2, 1, 2, 0, 0);
    add(PH_UEXIT, wake + 2, 2, 2, 2, 2, wake);
  endtask

  // Expand segments into per-cycle stimulus and expected phases. The cfg of the
  // next phase is only valid on the last cycle of the current one; noise elsewhere.
  task automatic flush(bit sel);
    for (int i = 0; i < seg_q.size(); i++) begin
      for (int j = 0; j < seg_q[i].len; j++) begin
        stim_t st;
        exp_t  e;
        bit    last = (j == seg_q[i].len - 1);
        st.hs = pick(last ? seg_q[i].hs_l : seg_q[i].hs_b);
        st.ul = pick(last ? seg_q[i].ul_l : seg_q[i].ul_b);
        st.lpx = TW'($urandom); st.prep = TW'($urandom); st.zero = TW'($urandom);
        st.pre = TW'($urandom); st.post = TW'($urandom); st.trail = TW'($urandom);
        st.wake = WW'($urandom);
        if (last && (i + 1 < seg_q.size())) st = set_cfg(st, seg_q[i+1].ph, seg_q[i+1].cfg);
        in_q.push_back(st);
        e.ph = seg_q[i].ph; e.first = (i == 0 && j == 0); e.sel = sel;
        exp_q.push_back(e);
      end
    end
    seg_q.delete();
  endtask

  task automatic push_rst_exp(int n, bit sel);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ph = PH_RST; e.first = 1'b0; e.sel = sel;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_level(int lvl, int budget);
    int n = 0;
    while (exp_q.size() > lvl) begin
      @(posedge clk);
      n++;
      if (n > budget) begin
        $display("FAIL drain_timeout: %0d entries left, required %0d", exp_q.size(), lvl);
        $fatal(1, "scoreboard did not drain");
      end
    end
  endtask

  // Expected {hs_rdy, ulps_active, clk_sync, lp_p, lp_n, hs_oe, hs_bit}; the IO
  // fields reflect the phase of the previous cycle.
  function automatic logic [6:0] expect_vec(int ph, int pph, logic pcs, logic cs);
    logic [1:0] lp;
    logic oe, bt;
    if (ph == PH_RST) return 7'b0001100;
    case (pph)
      PH_LP11:           lp = 2'b11;
      PH_LP01:           lp = 2'b01;
      PH_UENT, PH_UEXIT: lp = 2'b10;
      default:           lp = 2'b00;
    endcase
    oe = (pph >= PH_ZERO) && (pph <= PH_TRAIL);
    bt = pcs && (pph >= PH_PRE) && (pph <= PH_POST);
    return {ph == PH_CLK, ph == PH_ULPS, cs, lp, oe, bt};
  endfunction

  // Driver: sole writer of the request and cfg inputs.
  initial begin
    hs_req = 1'b0; ulps_req = 1'b0;
    cfg_lpx = '0; cfg_hs_prep = '0; cfg_hs_zero = '0; cfg_hs_pre = '0;
    cfg_hs_post = '0; cfg_hs_trail = '0; cfg_wakeup = '0;
    forever begin
      @(negedge clk);
      if (in_q.size() > 0) begin
        stim_t st;
        st = in_q.pop_front();
        hs_req = st.hs; ulps_req = st.ul;
        cfg_lpx = st.lpx; cfg_hs_prep = st.prep; cfg_hs_zero = st.zero; cfg_hs_pre = st.pre;
        cfg_hs_post = st.post; cfg_hs_trail = st.trail; cfg_wakeup = st.wake;
      end
    end
  end

  // Monitor
  initial begin
    int   k = 0;
    int   pph = PH_LP11;
    logic pcs = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t       e;
        logic [6:0] ev, av;
        logic       cs;
        e = exp_q.pop_front();
        if (e.first) begin
          k = 0; pph = PH_LP11; pcs = 1'b0;
        end
        cs = ((k % 2) == 1);
        ev = expect_vec(e.ph, pph, pcs, cs);
        av = e.sel ? {hs_rdy_c, ulps_active_c, clk_sync_c, io_lp_p_c, io_lp_n_c, io_hs_oe_c,
                      io_hs_bit_c}
                   : {hs_rdy, ulps_active, clk_sync, io_lp_p, io_lp_n, io_hs_oe, io_hs_bit};
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL %s phase %0d cycle %0d: got rdy/ulps/sync/p/n/oe/bit=%b required %b",
                   e.sel ? "cont" : "main", e.ph, k, av, ev);
        end
        pph = e.ph; pcs = cs; k++;
      end
    end
  end

  initial begin
    rst_n = 1'b1; rst_c_n = 1'b1;
    #1;
    rst_n = 1'b0; rst_c_n = 1'b0;
    // Reset holds everything idle even with hs_req asserted.
    for (int i = 0; i < 6; i++) begin
      stim_t st;
      st.hs = 1'b1; st.ul = 1'b0; st.lpx = '0; st.prep = '0; st.zero = '0; st.pre = '0;
      st.post = '0; st.trail = '0; st.wake = '0;
      in_q.push_back(st);
    end
    push_rst_exp(3, 1'b0);
    push_rst_exp(3, 1'b1);
    wait_level(0, 100);
    #1;

    add_idle(3, 1, 0);
    add_entry(1, 2, 5, 3);
    add_tail(6, 1'b0, 1'b0, 4, 2);
    add_idle(2, 1, 1);
    add_ulps(0, 5, 1000);
    add_idle(1, 1, 0);
    add_entry(rr(0, 4), rr(0, 4), 255, rr(0, 4));
    add_tail(rr(1, 5), 1'b0, 1'b0, rr(0, 4), rr(0, 4));
    for (int t = 0; t < 14; t++) begin
      if (rr(0, 2) == 0) begin
        add_idle(rr(1, 4), 2, 1);
        add_ulps(rr(0, 6), rr(1, 6), rr(0, 30));
      end else begin
        add_idle(rr(1, 4), 1, 0);
        add_entry(rr(0, 9), rr(0, 9), rr(0, 9), rr(0, 9));
        add_tail(rr(1, 8), 1'(rr(0, 1)), 1'b0, rr(0, 9), rr(0, 9));
      end
    end
    add_idle(3, 0, 0);
    flush(1'b0);
    rst_n = 1'b1;
    wait_level(0, 20000);
    #1;

    // Continuous clock: HS without hs_req, ULPS round trip, then reset mid HS_ZERO.
    add_idle(1, 0, 0);
    add_entry(rr(0, 5), rr(0, 5), rr(0, 5), rr(0, 5));
    add_tail(10, 1'b1, 1'b1, rr(0, 5), rr(0, 5));
    add_idle(1, 2, 1);
    add_ulps(rr(0, 5), 4, rr(0, 20));
    add_idle(1, 2, 0);
    add_entry(rr(0, 5), rr(0, 5), 30, 3);
    void'(seg_q.pop_back());
    seg_q[seg_q.size()-1].len = 4;
    flush(1'b1);
    push_rst_exp(2, 1'b1);
    rst_c_n = 1'b1;
    wait_level(2, 2000);
    #1;
    rst_c_n = 1'b0;
    wait_level(0, 100);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
